// File: rtl/rv32_mod_bus_arbiter_if.sv
// Bus bundle for the two-master / one-slave arbiter: fetch port, load/store port,
// shared memory port and status. 'slave' is the arbiter's view, 'master' is the environment's.
interface rv32_mod_bus_arbiter_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_ack;
  logic        instr_err;
  logic [31:0] instr_data_o;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_data_i;
  logic        data_ack;
  logic        data_err;
  logic [31:0] data_data_o;

  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_o;
  logic        mem_ack;
  logic        mem_err;
  logic [31:0] mem_data_i;

  logic        busy;
  logic        grant_data;

  modport slave (
    input  instr_req, instr_addr,
    input  data_req, data_wr, data_be, data_addr, data_data_i,
    input  mem_ack, mem_err, mem_data_i,
    output instr_ack, instr_err, instr_data_o,
    output data_ack, data_err, data_data_o,
    output mem_req, mem_wr, mem_be, mem_addr, mem_data_o,
    output busy, grant_data
  );

  modport master (
    output instr_req, instr_addr,
    output data_req, data_wr, data_be, data_addr, data_data_i,
    output mem_ack, mem_err, mem_data_i,
    input  instr_ack, instr_err, instr_data_o,
    input  data_ack, data_err, data_data_o,
    input  mem_req, mem_wr, mem_be, mem_addr, mem_data_o,
    input  busy, grant_data
  );
endinterface

// File: rtl/rv32_mod_bus_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with fixed or
// round-robin arbitration, zero-latency response routing and a response timeout.
module rv32_mod_bus_arbiter #(
  parameter int DATA_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                   clk,
  input logic                   reset,
  rv32_mod_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    TOUT   = 2'd3
  } state_t;

  localparam bit          FIXED_PRIORITY = (DATA_PRIORITY != 0);
  localparam bit          TIMEOUT_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TIMEOUT_LAST   = TIMEOUT_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  state_t      state_reg, state_next;
  logic        grant_data_reg, grant_data_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        mem_wr_reg, mem_wr_next;
  logic [3:0]  mem_be_reg, mem_be_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic        win_data;
  logic        responded;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      grant_data_reg <= 1'b0;
      cnt_reg        <= 16'd0;
      mem_wr_reg     <= 1'b0;
      mem_be_reg     <= 4'h0;
      mem_addr_reg   <= 32'h0;
      mem_wdata_reg  <= 32'h0;
    end else begin
      state_reg      <= state_next;
      grant_data_reg <= grant_data_next;
      cnt_reg        <= cnt_next;
      mem_wr_reg     <= mem_wr_next;
      mem_be_reg     <= mem_be_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
    end
  end

  // grant_data_reg doubles as the round-robin history: on a tie the other port wins.
  always_comb begin
    state_next      = state_reg;
    grant_data_next = grant_data_reg;
    cnt_next        = cnt_reg;
    mem_wr_next     = mem_wr_reg;
    mem_be_next     = mem_be_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    win_data        = bus.data_req && (!bus.instr_req || FIXED_PRIORITY || !grant_data_reg);
    responded       = bus.mem_ack || bus.mem_err;

    case (state_reg)
      IDLE: begin
        if (win_data) begin
          state_next      = BUSY_D;
          grant_data_next = 1'b1;
          cnt_next        = 16'd0;
          mem_wr_next     = bus.data_wr;
          mem_be_next     = bus.data_be;
          mem_addr_next   = bus.data_addr;
          mem_wdata_next  = bus.data_data_i;
        end else if (bus.instr_req) begin
          state_next      = BUSY_I;
          grant_data_next = 1'b0;
          cnt_next        = 16'd0;
          mem_wr_next     = 1'b0;
          mem_be_next     = 4'hF;
          mem_addr_next   = bus.instr_addr;
          mem_wdata_next  = 32'h0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (responded) begin
          state_next = IDLE;
        end else if (TIMEOUT_EN && (cnt_reg == TIMEOUT_LAST)) begin
          state_next = TOUT;
        end else if (cnt_reg != 16'hFFFF) begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      TOUT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Responses are steered to the granted port only; everything is held at 0 during reset.
  always_comb begin
    bus.instr_ack    = 1'b0;
    bus.instr_err    = 1'b0;
    bus.instr_data_o = 32'h0;
    bus.data_ack     = 1'b0;
    bus.data_err     = 1'b0;
    bus.data_data_o  = 32'h0;
    bus.mem_req      = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_be       = 4'h0;
    bus.mem_addr     = 32'h0;
    bus.mem_data_o   = 32'h0;
    bus.busy         = 1'b0;
    bus.grant_data   = 1'b0;
    if (!reset) begin
      bus.busy       = (state_reg != IDLE);
      bus.grant_data = grant_data_reg;
      bus.mem_req    = (state_reg == BUSY_I) || (state_reg == BUSY_D);
      bus.mem_wr     = mem_wr_reg;
      bus.mem_be     = mem_be_reg;
      bus.mem_addr   = mem_addr_reg;
      bus.mem_data_o = mem_wdata_reg;
      case (state_reg)
        BUSY_I: begin
          bus.instr_ack    = bus.mem_ack && !bus.mem_err;
          bus.instr_err    = bus.mem_err;
          bus.instr_data_o = bus.mem_data_i;
        end
        BUSY_D: begin
          bus.data_ack    = bus.mem_ack && !bus.mem_err;
          bus.data_err    = bus.mem_err;
          bus.data_data_o = bus.mem_data_i;
        end
        TOUT: begin
          bus.instr_err = !grant_data_reg;
          bus.data_err  = grant_data_reg;
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rv32_mod_bus_arbiter.sv
// Bench for rv32_mod_bus_arbiter: directed scenarios plus randomized traffic on a
// fixed-priority instance (dut_a) and a round-robin instance (dut_b), both with timeout 4.
module tb_rv32_mod_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cur = 1'b0;

  logic        ireq, dreq, dwr, mack, merr;
  logic [3:0]  dbe;
  logic [31:0] iaddr, daddr, dwdata, mrdata;

  int checks = 0;
  int errors = 0;

  rv32_mod_bus_arbiter_if ia ();
  rv32_mod_bus_arbiter_if ib ();

  rv32_mod_bus_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(4)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  rv32_mod_bus_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(4)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  // Only the selected instance sees stimulus; the other one idles.
  assign ia.instr_req   = cur ? 1'b0 : ireq;
  assign ia.instr_addr  = cur ? 32'h0 : iaddr;
  assign ia.data_req    = cur ? 1'b0 : dreq;
  assign ia.data_wr     = cur ? 1'b0 : dwr;
  assign ia.data_be     = cur ? 4'h0 : dbe;
  assign ia.data_addr   = cur ? 32'h0 : daddr;
  assign ia.data_data_i = cur ? 32'h0 : dwdata;
  assign ia.mem_ack     = cur ? 1'b0 : mack;
  assign ia.mem_err     = cur ? 1'b0 : merr;
  assign ia.mem_data_i  = cur ? 32'h0 : mrdata;
  assign ib.instr_req   = cur ? ireq : 1'b0;
  assign ib.instr_addr  = cur ? iaddr : 32'h0;
  assign ib.data_req    = cur ? dreq : 1'b0;
  assign ib.data_wr     = cur ? dwr : 1'b0;
  assign ib.data_be     = cur ? dbe : 4'h0;
  assign ib.data_addr   = cur ? daddr : 32'h0;
  assign ib.data_data_i = cur ? dwdata : 32'h0;
  assign ib.mem_ack     = cur ? mack : 1'b0;
  assign ib.mem_err     = cur ? merr : 1'b0;
  assign ib.mem_data_i  = cur ? mrdata : 32'h0;

  logic        o_iack, o_ierr, o_dack, o_derr, o_mem_req, o_mem_wr, o_busy, o_grant;
  logic [3:0]  o_mem_be;
  logic [31:0] o_idata, o_ddata, o_mem_addr, o_mem_wdata;
  logic [139:0] o_all;

  assign o_iack      = cur ? ib.instr_ack : ia.instr_ack;
  assign o_ierr      = cur ? ib.instr_err : ia.instr_err;
  assign o_idata     = cur ? ib.instr_data_o : ia.instr_data_o;
  assign o_dack      = cur ? ib.data_ack : ia.data_ack;
  assign o_derr      = cur ? ib.data_err : ia.data_err;
  assign o_ddata     = cur ? ib.data_data_o : ia.data_data_o;
  assign o_mem_req   = cur ? ib.mem_req : ia.mem_req;
  assign o_mem_wr    = cur ? ib.mem_wr : ia.mem_wr;
  assign o_mem_be    = cur ? ib.mem_be : ia.mem_be;
  assign o_mem_addr  = cur ? ib.mem_addr : ia.mem_addr;
  assign o_mem_wdata = cur ? ib.mem_data_o : ia.mem_data_o;
  assign o_busy      = cur ? ib.busy : ia.busy;
  assign o_grant     = cur ? ib.grant_data : ia.grant_data;
  assign o_all = {o_mem_req, o_mem_wr, o_mem_be, o_mem_addr, o_mem_wdata, o_iack, o_ierr, o_idata,
                  o_dack, o_derr, o_ddata, o_busy, o_grant};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    ireq = 1'b0; iaddr = 32'h0; dreq = 1'b0; dwr = 1'b0; dbe = 4'h0;
    daddr = 32'h0; dwdata = 32'h0; mack = 1'b0; merr = 1'b0; mrdata = 32'h0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    ireq = 1'b1; dreq = 1'b1; mack = 1'b1; mrdata = 32'hFFFF_FFFF;
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      cur = s[0];
      tick(); #1;
      checks++; if (o_all !== '0) begin errors++; $display("FAIL reset_held dut%0d got %h exp 0", s, o_all); end
    end
    clear_inputs();
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      cur = s[0]; #1;
      checks++; if (o_all !== '0) begin errors++; $display("FAIL reset_release dut%0d got %h exp 0", s, o_all); end
    end
  endtask

  task automatic test_single_fetch();
    cur = 1'b0;
    ireq = 1'b1; iaddr = 32'h1000_0000;
    tick(); #1;
    checks++; if ({o_mem_req, o_mem_wr, o_mem_be, o_mem_addr, o_mem_wdata} !== {1'b1, 1'b0, 4'hF, 32'h1000_0000, 32'h0})
      begin errors++; $display("FAIL fetch_mem got %b %b %h %h %h exp 1 0 f 10000000 0", o_mem_req, o_mem_wr, o_mem_be, o_mem_addr, o_mem_wdata); end
    checks++; if ({o_busy, o_grant} !== 2'b10) begin errors++; $display("FAIL fetch_status got %b%b exp 10", o_busy, o_grant); end
    mack = 1'b1; mrdata = 32'h0000_0013; #1;
    checks++; if ({o_iack, o_ierr, o_idata} !== {1'b1, 1'b0, 32'h0000_0013})
      begin errors++; $display("FAIL fetch_ack got %b %b %h exp 1 0 00000013", o_iack, o_ierr, o_idata); end
    checks++; if ({o_dack, o_derr, o_ddata} !== 34'h0) begin errors++; $display("FAIL fetch_other_port got %b %b %h exp 0", o_dack, o_derr, o_ddata); end
    tick();
    clear_inputs(); #1;
    checks++; if ({o_mem_req, o_busy, o_iack} !== 3'b000) begin errors++; $display("FAIL fetch_done got %b%b%b exp 000", o_mem_req, o_busy, o_iack); end
  endtask

  task automatic test_contention();
    cur = 1'b0;
    ireq = 1'b1; iaddr = 32'h1000_0040;
    dreq = 1'b1; dwr = 1'b1; dbe = 4'b0011; daddr = 32'h8000_0004; dwdata = 32'hDEAD_BEEF;
    tick(); #1;
    checks++; if ({o_grant, o_mem_req, o_mem_wr, o_mem_be, o_mem_addr, o_mem_wdata} !== {1'b1, 1'b1, 1'b1, 4'b0011, 32'h8000_0004, 32'hDEAD_BEEF})
      begin errors++; $display("FAIL prio_data_grant got %b %b %b %h %h %h", o_grant, o_mem_req, o_mem_wr, o_mem_be, o_mem_addr, o_mem_wdata); end
    mack = 1'b1; mrdata = 32'h1234_5678; #1;
    checks++; if ({o_dack, o_iack, o_ddata} !== {1'b1, 1'b0, 32'h1234_5678})
      begin errors++; $display("FAIL prio_data_ack got %b %b %h exp 1 0 12345678", o_dack, o_iack, o_ddata); end
    tick();
    dreq = 1'b0; mack = 1'b0; #1;
    checks++; if ({o_busy, o_mem_req} !== 2'b00) begin errors++; $display("FAIL prio_bubble got %b%b exp 00", o_busy, o_mem_req); end
    tick(); #1;
    checks++; if ({o_grant, o_mem_req, o_mem_wr, o_mem_be, o_mem_addr, o_mem_wdata} !== {1'b0, 1'b1, 1'b0, 4'hF, 32'h1000_0040, 32'h0})
      begin errors++; $display("FAIL prio_fetch_grant got %b %b %b %h %h %h", o_grant, o_mem_req, o_mem_wr, o_mem_be, o_mem_addr, o_mem_wdata); end
    mack = 1'b1; mrdata = 32'h0000_0093; #1;
    checks++; if ({o_iack, o_dack, o_idata} !== {1'b1, 1'b0, 32'h0000_0093})
      begin errors++; $display("FAIL prio_fetch_ack got %b %b %h exp 1 0 00000093", o_iack, o_dack, o_idata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_error_priority();
    cur = 1'b0;
    dreq = 1'b1; dwr = 1'b0; dbe = 4'hF; daddr = 32'h8000_0100;
    tick();
    mack = 1'b1; merr = 1'b1; #1;
    checks++; if ({o_dack, o_derr, o_iack, o_ierr} !== 4'b0100)
      begin errors++; $display("FAIL err_wins got ack=%b err=%b iack=%b ierr=%b exp 0 1 0 0", o_dack, o_derr, o_iack, o_ierr); end
    tick();
    clear_inputs(); #1;
    checks++; if ({o_busy, o_mem_req, o_derr} !== 3'b000) begin errors++; $display("FAIL err_idle got %b%b%b exp 000", o_busy, o_mem_req, o_derr); end
  endtask

  task automatic test_timeout();
    int n;
    logic early;
    cur = 1'b0;
    ireq = 1'b1; iaddr = 32'h1000_0200;
    tick();
    n = 0; early = 1'b0;
    while (o_mem_req === 1'b1 && n < 20) begin
      n++;
      if (o_iack || o_ierr) early = 1'b1;
      tick();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL timeout_req_cycles got %0d exp 4", n); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL timeout_early_resp got %b exp 0", early); end
    ireq = 1'b0; mack = 1'b1; #1;
    checks++; if ({o_ierr, o_iack, o_busy, o_mem_req} !== 4'b1010)
      begin errors++; $display("FAIL timeout_err got ierr=%b iack=%b busy=%b req=%b exp 1 0 1 0", o_ierr, o_iack, o_busy, o_mem_req); end
    tick(); #1;
    checks++; if ({o_ierr, o_iack, o_busy, o_mem_req} !== 4'b0000)
      begin errors++; $display("FAIL timeout_after got %b%b%b%b exp 0000", o_ierr, o_iack, o_busy, o_mem_req); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    cur = 1'b1;
    pulse_reset();
    dreq = 1'b1; dwr = 1'b0; dbe = 4'hF; daddr = 32'h8000_0300;
    tick(); #1;
    checks++; if ({o_busy, o_grant} !== 2'b11) begin errors++; $display("FAIL rmid_busy got %b%b exp 11", o_busy, o_grant); end
    tick();
    reset = 1'b1; dreq = 1'b0; mack = 1'b1; mrdata = 32'hCAFE_F00D; #1;
    checks++; if (o_all !== '0) begin errors++; $display("FAIL rmid_forced got %h exp 0", o_all); end
    tick();
    reset = 1'b0; #1;
    checks++; if (o_all !== '0) begin errors++; $display("FAIL rmid_after got %h exp 0", o_all); end
    mack = 1'b0;
    ireq = 1'b1; iaddr = 32'h1000_0300; dreq = 1'b1;
    tick(); #1;
    checks++; if ({o_grant, o_mem_addr} !== {1'b1, 32'h8000_0300})
      begin errors++; $display("FAIL rmid_rr_cleared got %b %h exp 1 80000300", o_grant, o_mem_addr); end
    mack = 1'b1;
    tick();
    dreq = 1'b0; mack = 1'b0;
    tick(); #1;
    checks++; if ({o_grant, o_mem_req, o_mem_addr} !== {1'b0, 1'b1, 32'h1000_0300})
      begin errors++; $display("FAIL rmid_fetch got %b %b %h exp 0 1 10000300", o_grant, o_mem_req, o_mem_addr); end
    mack = 1'b1; mrdata = 32'h0000_0113; #1;
    checks++; if ({o_iack, o_idata} !== {1'b1, 32'h0000_0113}) begin errors++; $display("FAIL rmid_fetch_ack got %b %h exp 1 00000113", o_iack, o_idata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [5:0] exp_seq;
    logic       exp_d;
    exp_seq = 6'b101010;
    cur = 1'b1;
    pulse_reset();
    ireq = 1'b1; iaddr = 32'h1000_0400; dreq = 1'b1; daddr = 32'h8000_0400; dbe = 4'hF;
    for (int k = 0; k < 6; k++) begin
      exp_d = exp_seq[5 - k];
      tick(); #1;
      checks++; if ({o_grant, o_mem_addr} !== {exp_d, exp_d ? 32'h8000_0400 : 32'h1000_0400})
        begin errors++; $display("FAIL rr_grant_%0d got %b %h exp %b", k, o_grant, o_mem_addr, exp_d); end
      mack = 1'b1; #1;
      checks++; if ({o_dack, o_iack} !== {exp_d, ~exp_d})
        begin errors++; $display("FAIL rr_ack_%0d got d=%b i=%b exp d=%b", k, o_dack, o_iack, exp_d); end
      tick();
      mack = 1'b0; #1;
      checks++; if ({o_busy, o_grant} !== {1'b0, exp_d}) begin errors++; $display("FAIL rr_bubble_%0d got %b%b", k, o_busy, o_grant); end
    end
    clear_inputs();
  endtask

  // Reference: tie -> data if fixed priority, else the port not granted last time;
  // response steered to the winner; 4 unanswered BUSY cycles -> one error cycle.
  task automatic test_random(input logic which, input int n);
    logic        last, pri, ir, dr, win_d, use_err;
    logic        exp_wr;
    logic [3:0]  exp_be, be_v;
    logic [31:0] exp_addr, exp_wd, ia_v, da_v, dw_v, rd_v;
    int          dly;
    cur = which;
    pri = ~which;
    pulse_reset();
    last = 1'b0;
    for (int t = 0; t < n; t++) begin
      ir = 1'($urandom); dr = 1'($urandom);
      ia_v = $urandom; da_v = $urandom; dw_v = $urandom; rd_v = $urandom; be_v = 4'($urandom);
      if (!ir && !dr) begin
        mack = 1'($urandom); merr = 1'($urandom); #1;
        checks++; if ({o_busy, o_mem_req, o_iack, o_ierr, o_dack, o_derr} !== 6'b0)
          begin errors++; $display("FAIL rnd_idle_stray t%0d got %b%b%b%b%b%b exp 0", t, o_busy, o_mem_req, o_iack, o_ierr, o_dack, o_derr); end
        tick();
        mack = 1'b0; merr = 1'b0;
        continue;
      end
      ireq = ir; iaddr = ia_v; dreq = dr; dwr = 1'($urandom); dbe = be_v; daddr = da_v; dwdata = dw_v;
      win_d    = dr && (!ir || pri || !last);
      exp_addr = win_d ? da_v : ia_v;
      exp_wr   = win_d ? dwr : 1'b0;
      exp_be   = win_d ? be_v : 4'hF;
      exp_wd   = win_d ? dw_v : 32'h0;
      tick(); #1;
      checks++; if ({o_grant, o_mem_req, o_mem_wr, o_mem_be, o_mem_addr, o_mem_wdata} !== {win_d, 1'b1, exp_wr, exp_be, exp_addr, exp_wd})
        begin errors++; $display("FAIL rnd_grant t%0d got %b %b %b %h %h %h exp %b 1 %b %h %h %h", t, o_grant, o_mem_req, o_mem_wr, o_mem_be, o_mem_addr, o_mem_wdata, win_d, exp_wr, exp_be, exp_addr, exp_wd); end
      dly = $urandom_range(0, 5);
      use_err = (($urandom % 4) == 0);
      for (int c = 0; c < 8; c++) begin
        // requesters may drop or wiggle inputs mid-transaction
        ireq = 1'($urandom); dreq = 1'($urandom); iaddr = $urandom; daddr = $urandom;
        if (c == dly) begin
          mack = use_err ? 1'($urandom) : 1'b1; merr = use_err; mrdata = rd_v; #1;
          checks++; if ({o_iack, o_ierr, o_dack, o_derr} !== {~win_d & ~use_err, ~win_d & use_err, win_d & ~use_err, win_d & use_err})
            begin errors++; $display("FAIL rnd_resp t%0d got %b%b%b%b win_d=%b err=%b", t, o_iack, o_ierr, o_dack, o_derr, win_d, use_err); end
          if (!use_err) begin
            checks++; if ({o_idata, o_ddata} !== {win_d ? 32'h0 : rd_v, win_d ? rd_v : 32'h0})
              begin errors++; $display("FAIL rnd_rdata t%0d got %h %h exp winner %h", t, o_idata, o_ddata, rd_v); end
          end
          tick();
          clear_inputs(); #1;
          checks++; if ({o_busy, o_mem_req, o_grant} !== {1'b0, 1'b0, win_d})
            begin errors++; $display("FAIL rnd_done t%0d got %b%b%b exp 00%b", t, o_busy, o_mem_req, o_grant, win_d); end
          break;
        end
        #1;
        checks++; if ({o_mem_req, o_busy, o_mem_addr, o_iack, o_ierr, o_dack, o_derr} !== {1'b1, 1'b1, exp_addr, 4'b0000})
          begin errors++; $display("FAIL rnd_wait t%0d c%0d got %b%b %h %b%b%b%b exp 11 %h 0000", t, c, o_mem_req, o_busy, o_mem_addr, o_iack, o_ierr, o_dack, o_derr, exp_addr); end
        if (c == 3) begin
          tick();
          ireq = 1'b0; dreq = 1'b0; mack = 1'($urandom); #1;
          checks++; if ({o_mem_req, o_busy, o_ierr, o_derr, o_iack, o_dack} !== {1'b0, 1'b1, ~win_d, win_d, 2'b00})
            begin errors++; $display("FAIL rnd_timeout t%0d got %b%b%b%b%b%b win_d=%b", t, o_mem_req, o_busy, o_ierr, o_derr, o_iack, o_dack, win_d); end
          tick();
          clear_inputs(); #1;
          checks++; if ({o_busy, o_ierr, o_derr} !== 3'b000) begin errors++; $display("FAIL rnd_tout_idle t%0d got %b%b%b exp 000", t, o_busy, o_ierr, o_derr); end
          break;
        end
        tick();
      end
      last = win_d;
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_contention();
    test_error_priority();
    test_timeout();
    test_reset_mid();
    test_round_robin();
    test_random(1'b0, 60);
    test_random(1'b1, 60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
